// File: rtl/vram_arbiter.sv
// vram_arbiter: two-master round-robin arbiter in front of the CPU-side
// wishbone port of the dual-port VRAM. It registers the winning request onto
// the slave and returns exactly one ack (with read data) per transaction.
// After every transaction it inserts a one-cycle GAP so that the slave's
// registered ack can fall before the next strobe.
//
// Optional feature: define VRAM_ARB_TIMEOUT_EN to abort a GRANT that sees no
// slave ack within TIMEOUT cycles. The owner then gets an err pulse instead
// of an ack. Without the macro, GRANT waits forever and m*_err are tied to 0.
module vram_arbiter
`ifdef VRAM_ARB_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT = 255   // legal 1..255
)
`endif
(
   input  logic        clk,
   input  logic        rst_n,
   // master 0: CPU data bus
   input  logic        m0_stb,
   input  logic        m0_we,
   input  logic [31:0] m0_adr,
   input  logic [31:0] m0_dat_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack,
   output logic        m0_err,
   // master 1: secondary VRAM master (scroll/clear DMA)
   input  logic        m1_stb,
   input  logic        m1_we,
   input  logic [31:0] m1_adr,
   input  logic [31:0] m1_dat_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack,
   output logic        m1_err,
   // VRAM slave port
   output logic        s_stb,
   output logic        s_we,
   output logic [31:0] s_adr,
   output logic [31:0] s_dat_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack,
   // status
   output logic [1:0]  grant,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   last_m1;    // 1: m1 was granted last, so m0 wins the next tie
   logic   owner_m1;   // owner of the transaction in flight
   logic   any_req;
   logic   win_m1;
   logic   tmo_hit;

   assign any_req = m0_stb | m1_stb;
   // A lone requester wins; on a tie the master not granted last wins.
   assign win_m1  = m1_stb & (~m0_stb | ~last_m1);
   assign busy    = (state != IDLE);

`ifdef VRAM_ARB_TIMEOUT_EN
   logic [7:0] tmo_cnt;

   // Abort on the cycle the count would reach TIMEOUT; an ack in that cycle wins.
   assign tmo_hit = (state == GRANT) & ~s_ack & (tmo_cnt == 8'(TIMEOUT - 1));

   // Count GRANT cycles without ack; held at zero outside GRANT so entry starts from 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tmo_cnt <= '0;
      else if (state != GRANT)
         tmo_cnt <= '0;
      else if (!s_ack)
         tmo_cnt <= tmo_cnt + 8'd1;
   end

   // Error pulse to the owner of an aborted transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0_err <= 1'b0;
         m1_err <= 1'b0;
      end else begin
         m0_err <= tmo_hit & ~owner_m1;
         m1_err <= tmo_hit &  owner_m1;
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign m0_err  = 1'b0;
   assign m1_err  = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
      state_nxt = state;
      unique case (state)
         IDLE:    if (any_req) state_nxt = GRANT;
         GRANT:   if (s_ack || tmo_hit) state_nxt = GAP;
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Latch the winner onto the slave port, track ownership and pulse the owner's ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_stb    <= 1'b0;
         s_we     <= 1'b0;
         s_adr    <= '0;
         s_dat_o  <= '0;
         grant    <= '0;
         owner_m1 <= 1'b0;
         last_m1  <= 1'b1;
         m0_ack   <= 1'b0;
         m1_ack   <= 1'b0;
         m0_dat_o <= '0;
         m1_dat_o <= '0;
      end else begin
         m0_ack   <= 1'b0;
         m1_ack   <= 1'b0;
         m0_dat_o <= '0;
         m1_dat_o <= '0;
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  owner_m1 <= win_m1;
                  grant    <= win_m1 ? 2'b10 : 2'b01;
                  s_stb    <= 1'b1;
                  s_we     <= win_m1 ? m1_we    : m0_we;
                  s_adr    <= win_m1 ? m1_adr   : m0_adr;
                  s_dat_o  <= win_m1 ? m1_dat_i : m0_dat_i;
               end
            end
            GRANT: begin
               if (s_ack) begin
                  s_stb <= 1'b0;
                  if (owner_m1) begin
                     m1_ack   <= 1'b1;
                     m1_dat_o <= s_we ? 32'h0 : s_dat_i;
                  end else begin
                     m0_ack   <= 1'b1;
                     m0_dat_o <= s_we ? 32'h0 : s_dat_i;
                  end
               end else if (tmo_hit) begin
                  s_stb <= 1'b0;
               end
            end
            GAP: begin
               last_m1 <= owner_m1;
               grant   <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter. Master drivers push the
// expected response of every request into a per-master queue; a negedge
// monitor pops and compares on each ack, checks every slave-side transfer
// against the owner's queued request, and checks the round-robin choice with
// a small model of the arbitration rule.
`timescale 1ns/1ps
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m0_stb = 1'b0, m0_we = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
   logic [31:0] m0_adr = '0, m0_dat_i = '0, m1_adr = '0, m1_dat_i = '0;
   logic [31:0] m0_dat_o, m1_dat_o;
   logic        m0_ack, m1_ack, m0_err, m1_err;
   logic        s_stb, s_we;
   logic [31:0] s_adr, s_dat_o;
   logic [31:0] s_dat_i = '0;
   logic        s_ack = 1'b0;
   logic [1:0]  grant;
   logic        busy;

   vram_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat_i(m0_dat_i),
      .m0_dat_o(m0_dat_o), .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dat_i(m1_dat_i),
      .m1_dat_o(m1_dat_o), .m1_ack(m1_ack), .m1_err(m1_err),
      .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
      .s_dat_i(s_dat_i), .s_ack(s_ack),
      .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [31:0] exp_dat;
      int          issue;
      int          lat;     // expected request-to-ack cycles, -1 if not predicted
   } txn_t;

   txn_t q0[$];
   txn_t q1[$];
   bit   win_q[$];          // winners in grant order (1 = m1)

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int slave_wait = 0;      // extra ack-low cycles, -1 = random 0..2
   int wait_left = 0;
   int slave_txns = 0;
   int last_tb = 1;         // reference pointer: 1 = m1 granted last
   logic [1:0] prev_stb = '0;
   logic [1:0] prev_grant = '0;
   logic [1:0] exp_g;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Slave read data rule: a fixed scramble of the address.
   function automatic logic [31:0] rd_model(input logic [31:0] adr);
      return adr ^ 32'hDEAD_BEFF;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // VRAM slave model: ack is a registered copy of stb after optional wait cycles.
   always @(posedge clk) begin
      if (s_stb && !s_ack) begin
         if (wait_left > 0) begin
            wait_left <= wait_left - 1;
            s_ack     <= 1'b0;
            s_dat_i   <= $urandom;
         end else begin
            s_ack   <= 1'b1;
            s_dat_i <= s_we ? $urandom : rd_model(s_adr);
         end
      end else begin
         s_ack     <= 1'b0;
         s_dat_i   <= $urandom;
         wait_left <= (slave_wait < 0) ? int'($urandom_range(0, 2)) : slave_wait;
      end
   end

   // Pop and compare the owner's expected response on its ack.
   task automatic handle_ack(input int m);
      txn_t t;
      logic [31:0] dat;
      int qsz;
      dat = (m == 0) ? m0_dat_o : m1_dat_o;
      qsz = (m == 0) ? q0.size() : q1.size();
      check("ack_has_request", 32'(qsz != 0), 32'd1);
      if (qsz == 0) return;
      if (m == 0) t = q0.pop_front();
      else        t = q1.pop_front();
      check((m == 0) ? "m0_dat_o" : "m1_dat_o", dat, t.exp_dat);
      if (t.lat >= 0) check("ack_latency", 32'(cyc - t.issue), 32'(t.lat));
      check("gap_s_stb", 32'(s_stb), 32'd0);
      check("gap_grant", 32'(grant), (m == 0) ? 32'd1 : 32'd2);
      last_tb = m;
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         last_tb    = 1;
         prev_grant = '0;
      end else begin
         check("grant_not_both", 32'(grant == 2'b11), 32'd0);
         check("busy", 32'(busy), 32'(grant != 2'b00));
         check("m0_err", 32'(m0_err), 32'd0);
         check("m1_err", 32'(m1_err), 32'd0);
         check("acks_exclusive", 32'(m0_ack & m1_ack), 32'd0);
         if (!m0_ack) check("m0_dat_o_idle", m0_dat_o, 32'd0);
         if (!m1_ack) check("m1_dat_o_idle", m1_dat_o, 32'd0);

         if (prev_grant == 2'b00 && grant != 2'b00) begin
            case (prev_stb)
               2'b01:   exp_g = 2'b01;
               2'b10:   exp_g = 2'b10;
               2'b11:   exp_g = (last_tb == 1) ? 2'b01 : 2'b10;
               default: exp_g = 2'b00;
            endcase
            check("rr_winner", 32'(grant), 32'(exp_g));
            check("grant_s_stb", 32'(s_stb), 32'd1);
            win_q.push_back(grant[1]);
         end

         if (s_stb && s_ack) begin
            txn_t t;
            bit   ok;
            slave_txns++;
            ok = 1'b0;
            if (grant == 2'b01 && q0.size() != 0) begin t = q0[0]; ok = 1'b1; end
            if (grant == 2'b10 && q1.size() != 0) begin t = q1[0]; ok = 1'b1; end
            check("slave_owner_has_request", 32'(ok), 32'd1);
            if (ok) begin
               check("s_we", 32'(s_we), 32'(t.we));
               check("s_adr", s_adr, t.adr);
               if (t.we) check("s_dat_o", s_dat_o, t.dat);
            end
         end

         if (m0_ack) handle_ack(0);
         if (m1_ack) handle_ack(1);
      end
      prev_stb   = {m1_stb, m0_stb};
      prev_grant = grant;
   end

   // Issue one request on master m and wait (bounded) for its ack.
   task automatic drive_txn(input int m, input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input int lat, input bit keep,
                            input bit scramble);
      txn_t t;
      bit   done;
      bit   scr_done;
      done     = 1'b0;
      scr_done = 1'b0;
      @(posedge clk); #1;
      t.we      = we;
      t.adr     = adr;
      t.dat     = dat;
      t.exp_dat = we ? 32'h0 : rd_model(adr);
      t.issue   = cyc;
      t.lat     = lat;
      if (m == 0) begin
         m0_we = we; m0_adr = adr; m0_dat_i = dat; m0_stb = 1'b1;
         q0.push_back(t);
      end else begin
         m1_we = we; m1_adr = adr; m1_dat_i = dat; m1_stb = 1'b1;
         q1.push_back(t);
      end
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if ((m == 0) ? m0_ack : m1_ack) begin
            done = 1'b1;
         end else if (scramble && !scr_done && grant[m]) begin
            // Request is latched now; later changes on the master side must be ignored.
            scr_done = 1'b1;
            if (m == 0) begin m0_adr = $urandom; m0_dat_i = $urandom; end
            else        begin m1_adr = $urandom; m1_dat_i = $urandom; end
         end
      end
      check((m == 0) ? "m0_ack_within_bound" : "m1_ack_within_bound", 32'(done), 32'd1);
      if (!keep) begin
         @(posedge clk); #1;
         if (m == 0) m0_stb = 1'b0;
         else        m1_stb = 1'b0;
      end
   endtask

   initial begin
      int  n;
      bit  seen;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_stb", 32'(s_stb), 32'd0);
      check("rst_s_we", 32'(s_we), 32'd0);
      check("rst_s_adr", s_adr, 32'd0);
      check("rst_s_dat_o", s_dat_o, 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_m0_ack", 32'(m0_ack), 32'd0);
      check("rst_m1_ack", 32'(m1_ack), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Single m0 read: ack 3 cycles after the request, one slave transfer.
      n = slave_txns;
      drive_txn(0, 1'b0, 32'h0000_0010, 32'h0, 3, 1'b0, 1'b1);
      check("t1_read_data_rule", rd_model(32'h0000_0010), 32'hDEAD_BEEF);
      check("t1_slave_txns", 32'(slave_txns - n), 32'd1);

      // Single m1 write.
      n = slave_txns;
      drive_txn(1, 1'b1, 32'h0000_0004, 32'h1234_5678, 3, 1'b0, 1'b1);
      check("t2_slave_txns", 32'(slave_txns - n), 32'd1);

      // Both masters hold requests across three transactions: m0, m1, m0.
      win_q.delete();
      fork
         begin
            drive_txn(0, 1'b1, 32'h0000_0100, 32'hA5A5_0001, -1, 1'b1, 1'b1);
            drive_txn(0, 1'b0, 32'h0000_0104, 32'h0, -1, 1'b0, 1'b1);
         end
         drive_txn(1, 1'b0, 32'h0000_0200, 32'h0, -1, 1'b0, 1'b1);
      join
      check("t3_grant_count", 32'(win_q.size()), 32'd3);
      if (win_q.size() == 3) begin
         check("t3_first_m0", 32'(win_q[0]), 32'd0);
         check("t3_second_m1", 32'(win_q[1]), 32'd1);
         check("t3_third_m0", 32'(win_q[2]), 32'd0);
      end

      // Slave holds ack low 5 extra cycles: ack at cycle 8, one slave transfer.
      slave_wait = 5;
      repeat (2) @(posedge clk);
      n = slave_txns;
      drive_txn(0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 8, 1'b0, 1'b1);
      check("t4_slave_txns", 32'(slave_txns - n), 32'd1);
      slave_wait = 0;
      repeat (2) @(posedge clk);

      // Asynchronous reset in GRANT drops the transaction; the held request is re-arbitrated.
      n = slave_txns;
      fork
         drive_txn(0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, -1, 1'b0, 1'b0);
         begin
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
               @(negedge clk);
               seen = (grant == 2'b01);
            end
            check("t5_grant_reached", 32'(seen), 32'd1);
            #1 rst_n = 1'b0;
            #1;
            check("t5_rst_s_stb", 32'(s_stb), 32'd0);
            check("t5_rst_s_we", 32'(s_we), 32'd0);
            check("t5_rst_s_adr", s_adr, 32'd0);
            check("t5_rst_s_dat_o", s_dat_o, 32'd0);
            check("t5_rst_grant", 32'(grant), 32'd0);
            check("t5_rst_busy", 32'(busy), 32'd0);
            @(posedge clk);
            #3 rst_n = 1'b1;
         end
      join
      check("t5_slave_txns", 32'(slave_txns - n), 32'd1);

      // Randomized traffic from both masters with random slave wait states.
      slave_wait = -1;
      fork
         for (int i = 0; i < 30; i++) begin
            bit k;
            k = (i < 29) ? 1'($urandom_range(0, 1)) : 1'b0;
            drive_txn(0, 1'($urandom_range(0, 1)), $urandom, $urandom, -1, k, 1'b1);
            if (!k) repeat ($urandom_range(0, 3)) @(posedge clk);
         end
         for (int j = 0; j < 30; j++) begin
            bit k;
            k = (j < 29) ? 1'($urandom_range(0, 1)) : 1'b0;
            drive_txn(1, 1'($urandom_range(0, 1)), $urandom, $urandom, -1, k, 1'b1);
            if (!k) repeat ($urandom_range(0, 3)) @(posedge clk);
         end
      join
      repeat (10) @(posedge clk);
      check("q0_drained", 32'(q0.size()), 32'd0);
      check("q1_drained", 32'(q1.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
